control_pad_scanner: RTL and testbench
======================================

// Module: control_pad_scanner
// PURPOSE
//  Front end for the object-control path. Samples 12 raw push-buttons (asynchronous to fclk)
//  and turns them into the 12-bit controlPad step-strobe bus that the object state stage
//  consumes: six 2-bit pairs, each 2'b10=positive, 2'b01=negative, 2'b00=no step.
//  Adds synchronisation, debounce, pair-conflict masking and press/hold auto-repeat,
//  so one tap gives exactly one step and a held button gives a paced step stream.
// PARAMETERS
//  CNT_W            20      width of debounce/repeat counters
//  DEBOUNCE_CYCLES  1000    consecutive stable cycles required to accept a level change (>=1)
//  REPEAT_DELAY     200000  cycles from first strobe to first auto-repeat strobe (>=2)
//  REPEAT_PERIOD    50000   cycles between auto-repeat strobes (>=4)
// PORTS
//  fclk        in   1   system clock
//  rst         in   1   reset, asynchronous, active-high
//  btn_raw     in   12  raw buttons, active-high, same bit map as controlPad
//  controlPad  out  12  {FB,LR,UD,rotX,rotY,rotZ}; bit 2k+1=positive/F/Left/Up, bit 2k=negative
//  pad_active  out  1   high while any pair FSM is not IDLE
// BEHAVIOUR
//  Reset (async): sync flops, debounced levels, counters = 0; all pair FSMs IDLE;
//   controlPad = 12'h000; pad_active = 0. Reset mid-hold aborts the hold with no further strobe.
//  Sync: 2-flop synchroniser per bit (sync_q).
//  Debounce per bit: counter clears whenever sync_q == stable; otherwise increments;
//   when it reaches DEBOUNCE_CYCLES-1 the stable bit takes the sync_q value and the counter clears.
//   A pulse shorter than DEBOUNCE_CYCLES produces no change.
//  Pair decode: dir_k = {stable[2k+1], stable[2k]}; 2'b11 is treated as 2'b00 (conflict).
//  Per-pair FSM (six independent instances, one counter each):
//   IDLE  : dir_k in {10,01} -> strobe, latch dir_k, cnt=0, -> HOLD.
//   HOLD  : dir_k==00 -> IDLE. dir_k!=latched -> strobe the new direction, relatch, cnt=0, stay.
//           else cnt++; at cnt==REPEAT_DELAY-1 -> strobe, cnt=0, -> RPT.
//   RPT   : dir_k==00 -> IDLE. dir_k!=latched -> strobe, relatch, cnt=0, -> HOLD.
//           else cnt++; at cnt==period-1 -> strobe, cnt=0.
//  Strobe: controlPad[2k+1:2k] = latched direction for exactly one cycle, registered;
//   it appears in the cycle after the FSM decision. In all other cycles the pair is 2'b00.
//  Latency: raw edge -> strobe = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
//  Held button strobe times: t0, t0+REPEAT_DELAY, then every period cycles.
//  Pairs are fully independent; simultaneous strobes on several pairs share the same cycle.
//  Release: no strobe on release. The counter in use clears on entry to IDLE.
//  pad_active = OR over pairs of (state != IDLE), registered.
//  Counters saturate-free; parameter values must fit CNT_W.
// CONFIGURATION
//  PAD_ACCEL_EN defined:
//   - Each pair counts RPT strobes (4-bit, saturating).
//   - After 8 RPT strobes, the period becomes REPEAT_PERIOD/4.
//   - The strobe count clears when the pair leaves RPT.
//  PAD_ACCEL_EN undefined: period = REPEAT_PERIOD always; no strobe counter is built.
// TESTING (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
//  1 Tap: btn_raw[11]=1 for 12 cycles -> single 12'h800 pulse, 7 cycles after the rise;
//    no further strobes; pad_active returns to 0 after the release is debounced.
//  2 Glitch: btn_raw[0]=1 for 3 cycles -> controlPad stays 12'h000; pad_active stays 0.
//  3 Hold: btn_raw[1]=1 for 60 cycles, first strobe at t0 -> 12'h002 at t0, t0+20, t0+28,
//    t0+36, t0+44, t0+52; nothing after release.
//  4 Conflict/parallel: btn_raw=12'h300 -> controlPad 12'h000, and the pair remains IDLE.
//    btn_raw=12'h820 from the same cycle -> 12'h820 in a single cycle.
//  5 Reversal: hold btn_raw[3], then switch to btn_raw[2] with no gap ->
//    12'h004 strobe immediately after the debounce, then the HOLD timing restarts.
//  6 Reset: assert rst mid-RPT -> controlPad=0 with no clock edge needed; button still held
//    at rst release -> fresh strobe 7 cycles later.
//  7 PAD_ACCEL_EN: hold btn_raw[10] -> after 8 RPT strobes, the spacing changes from 8 to 2 cycles.

Source files
------------

// File: rtl/control_pad_scanner.sv
// ---------------------------------------------------------------------------
// control_pad_scanner
//
// Front end for the object-control path. Twelve raw push-buttons are
// synchronised, debounced, grouped into six direction pairs, and turned into
// one-cycle step strobes with press/hold auto-repeat. One tap gives exactly
// one step. A held button first gives a step, then another after
// REPEAT_DELAY cycles, then one every repeat period.
//
// Ports
//   fclk        in   1   system clock
//   rst         in   1   asynchronous, active-high reset
//   btn_raw     in  12   raw buttons, active-high, same bit map as controlPad
//   controlPad  out 12   {FB,LR,UD,rotX,rotY,rotZ}; per pair 2'b10 = positive,
//                        2'b01 = negative, 2'b00 = no step (one-cycle strobes)
//   pad_active  out  1   high while any pair is holding a direction
//
// Optional feature
//   PAD_ACCEL_EN  When defined, each pair counts its auto-repeat strobes
//                 (4-bit, saturating). After 8 of them the repeat period
//                 drops to REPEAT_PERIOD/4. The count clears when the pair
//                 leaves the repeat state.
// ---------------------------------------------------------------------------
module control_pad_scanner #(
    parameter int CNT_W           = 20,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_DELAY    = 200000,
    parameter int REPEAT_PERIOD   = 50000
) (
    input  logic        fclk,
    input  logic        rst,
    input  logic [11:0] btn_raw,
    output logic [11:0] controlPad,
    output logic        pad_active
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
`ifdef PAD_ACCEL_EN
    localparam logic [CNT_W-1:0] FAST_LAST   = CNT_W'(REPEAT_PERIOD / 4 - 1);
`endif

    logic [11:0] sync_meta_reg;
    logic [11:0] sync_q;
    logic [11:0] stable;
    logic [5:0]  pair_busy;

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            sync_meta_reg <= '0;
            sync_q        <= '0;
        end else begin
            sync_meta_reg <= btn_raw;
            sync_q        <= sync_meta_reg;
        end
    end

    // Per-bit debounce: the level is accepted only after DEBOUNCE_CYCLES
    // consecutive samples that disagree with the current stable value.
    for (genvar gi = 0; gi < 12; gi++) begin : g_debounce
        logic             stable_reg;
        logic [CNT_W-1:0] cnt_reg;

        always_ff @(posedge fclk or posedge rst) begin
            if (rst) begin
                stable_reg <= 1'b0;
                cnt_reg    <= '0;
            end else if (sync_q[gi] == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == DB_LAST) begin
                stable_reg <= sync_q[gi];
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end

        assign stable[gi] = stable_reg;
    end

    // Per-pair press/hold/repeat FSM.
    for (genvar gi = 0; gi < 6; gi++) begin : g_pair
        logic [1:0]       dir;
        state_t           state_reg;
        logic [1:0]       latched_reg;
        logic [CNT_W-1:0] cnt_reg;
        logic [1:0]       strobe_reg;
        logic [CNT_W-1:0] period_last;

        // Both buttons of a pair pressed together cancel out.
        assign dir = (stable[2*gi+1] & stable[2*gi]) ? 2'b00 : stable[2*gi +: 2];

        // Every state goes to IDLE exactly when dir is 00 and leaves IDLE
        // otherwise. So dir != 00 is the pair's next-state busy flag. That
        // keeps pad_active aligned with the registered state.
        assign pair_busy[gi] = (dir != 2'b00);

        assign controlPad[2*gi +: 2] = strobe_reg;

`ifdef PAD_ACCEL_EN
        logic [3:0] rpt_cnt_reg;
        logic       rpt_fire;
        logic       rpt_leave;

        assign period_last = (rpt_cnt_reg >= 4'd8) ? FAST_LAST : PERIOD_LAST;
        assign rpt_leave   = (state_reg == RPT) && (dir != latched_reg);
        assign rpt_fire    = (state_reg == RPT) && (dir == latched_reg) &&
                             (cnt_reg == period_last);

        always_ff @(posedge fclk or posedge rst) begin
            if (rst) begin
                rpt_cnt_reg <= 4'd0;
            end else if (rpt_leave) begin
                rpt_cnt_reg <= 4'd0;
            end else if (rpt_fire && (rpt_cnt_reg != 4'hF)) begin
                rpt_cnt_reg <= rpt_cnt_reg + 4'd1;
            end
        end
`else
        assign period_last = PERIOD_LAST;
`endif

        always_ff @(posedge fclk or posedge rst) begin
            if (rst) begin
                state_reg   <= IDLE;
                latched_reg <= 2'b00;
                cnt_reg     <= '0;
                strobe_reg  <= 2'b00;
            end else begin
                strobe_reg <= 2'b00;
                case (state_reg)
                    IDLE: begin
                        cnt_reg <= '0;
                        if (dir != 2'b00) begin
                            strobe_reg  <= dir;
                            latched_reg <= dir;
                            state_reg   <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (dir == 2'b00) begin
                            cnt_reg   <= '0;
                            state_reg <= IDLE;
                        end else if (dir != latched_reg) begin
                            strobe_reg  <= dir;
                            latched_reg <= dir;
                            cnt_reg     <= '0;
                        end else if (cnt_reg == DELAY_LAST) begin
                            strobe_reg <= dir;
                            cnt_reg    <= '0;
                            state_reg  <= RPT;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                    RPT: begin
                        if (dir == 2'b00) begin
                            cnt_reg   <= '0;
                            state_reg <= IDLE;
                        end else if (dir != latched_reg) begin
                            // A reversal restarts the full hold delay.
                            strobe_reg  <= dir;
                            latched_reg <= dir;
                            cnt_reg     <= '0;
                            state_reg   <= HOLD;
                        end else if (cnt_reg == period_last) begin
                            strobe_reg <= dir;
                            cnt_reg    <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                    default: begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            pad_active <= 1'b0;
        end else begin
            pad_active <= |pair_busy;
        end
    end

endmodule

// File: tb/tb_control_pad_scanner.sv
// ---------------------------------------------------------------------------
// tb_control_pad_scanner
//
// Directed scenarios (tap, glitch, hold, conflict, reversal, reset, long
// hold) followed by random button patterns.
//
// Each cycle is compared against a reference model. The model computes the
// debounced levels with a sliding window over the synchronised samples. It
// derives strobes from the time elapsed since each pair's current direction
// began: the start of the direction, then REPEAT_DELAY after it, then every
// period.
// ---------------------------------------------------------------------------
module tb_control_pad_scanner;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int P  = 8;

    logic        fclk = 1'b0;
    logic        rst  = 1'b1;
    logic [11:0] btn_raw = 12'h000;
    logic [11:0] controlPad;
    logic        pad_active;

    always #5 fclk = ~fclk;

    control_pad_scanner #(
        .CNT_W          (20),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (P)
    ) dut (
        .fclk      (fclk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .controlPad(controlPad),
        .pad_active(pad_active)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Reference model state.
    logic [11:0] raw_q[$];
    logic [11:0] win_q[$];
    logic [11:0] stable_m;
    logic [1:0]  prev_dir[6];
    int          run_start[6];
    int          edge_n;
    logic [11:0] exp_pad;
    logic        exp_act;

    // Observation helpers for the directed scenarios.
    logic [11:0] watch_val;
    int          watch_hits;
    int          watch_first;
    int          nz_hits;
    int          act_hits;

    // Is a strobe due d cycles after a direction began?
    function automatic bit strobe_due(int d);
        int m;
        if (d == 0) return 1'b1;
        if (d < RD) return 1'b0;
        m = d - RD;
`ifdef PAD_ACCEL_EN
        if (m <= 8 * P) return (m % P) == 0;
        return ((m - 8 * P) % (P / 4)) == 0;
`else
        return (m % P) == 0;
`endif
    endfunction

    task automatic model_reset();
        raw_q.delete();
        raw_q.push_back(12'h000);
        raw_q.push_back(12'h000);
        win_q.delete();
        stable_m = 12'h000;
        for (int k = 0; k < 6; k++) begin
            prev_dir[k]  = 2'b00;
            run_start[k] = 0;
        end
        edge_n  = 0;
        exp_pad = 12'h000;
        exp_act = 1'b0;
    endtask

    task automatic model_edge();
        logic [11:0] sync_now;
        logic [1:0]  d;
        bit          all_diff;
        edge_n++;
        raw_q.push_back(btn_raw);
        sync_now = raw_q.pop_front();
        exp_pad  = 12'h000;
        exp_act  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            d = stable_m[2*k +: 2];
            if (d == 2'b11) d = 2'b00;
            if (d != 2'b00) begin
                exp_act = 1'b1;
                if (d != prev_dir[k]) run_start[k] = edge_n;
                if (strobe_due(edge_n - run_start[k])) exp_pad[2*k +: 2] = d;
            end
            prev_dir[k] = d;
        end
        win_q.push_back(sync_now);
        if (win_q.size() > D) void'(win_q.pop_front());
        if (win_q.size() == D) begin
            for (int b = 0; b < 12; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < D; j++)
                    if (win_q[j][b] == stable_m[b]) all_diff = 1'b0;
                if (all_diff) stable_m[b] = ~stable_m[b];
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        n_total++;
        assert (got === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s edge=%0d got=%h want=%h", tag, edge_n, got, want);
        end
    endtask

    task automatic watch(logic [11:0] v);
        watch_val   = v;
        watch_hits  = 0;
        watch_first = -1;
        nz_hits     = 0;
        act_hits    = 0;
    endtask

    task automatic tick();
        @(posedge fclk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        check("pad", {20'd0, controlPad}, {20'd0, exp_pad});
        check("active", {31'd0, pad_active}, {31'd0, exp_act});
        if (controlPad === watch_val) begin
            if (watch_hits == 0) watch_first = edge_n;
            watch_hits++;
        end
        if (controlPad !== 12'h000) nz_hits++;
        if (pad_active !== 1'b0) act_hits++;
    endtask

    initial begin
        int mark;
        int n;
        model_reset();
        watch(12'h000);

        // Reset state.
        repeat (3) tick();
        check("reset_pad", {20'd0, controlPad}, 32'h0);
        rst = 1'b0;

        // Tap: one strobe, 7 cycles after the rise.
        watch(12'h800);
        mark = edge_n;
        btn_raw = 12'h800;
        repeat (12) tick();
        btn_raw = 12'h000;
        repeat (15) tick();
        check("tap_hits", watch_hits, 1);
        check("tap_lat", watch_first - mark, 7);
        check("tap_idle", {31'd0, pad_active}, 32'd0);
        $display("tap: hits=%0d latency=%0d", watch_hits, watch_first - mark);

        // Glitch shorter than the debounce window.
        watch(12'h001);
        btn_raw = 12'h001;
        repeat (3) tick();
        btn_raw = 12'h000;
        repeat (12) tick();
        check("glitch_pad", nz_hits, 0);
        check("glitch_act", act_hits, 0);
        $display("glitch: nonzero=%0d active=%0d", nz_hits, act_hits);

        // Hold for 60 cycles: strobes at t0, +20, +28, +36, +44, +52.
        watch(12'h002);
        mark = edge_n;
        btn_raw = 12'h002;
        repeat (60) tick();
        btn_raw = 12'h000;
        repeat (20) tick();
        check("hold_hits", watch_hits, 6);
        check("hold_lat", watch_first - mark, 7);
        $display("hold: hits=%0d", watch_hits);

        // Conflicting pair plus two independent pairs in parallel.
        watch(12'h820);
        btn_raw = 12'hB20;
        repeat (12) tick();
        btn_raw = 12'h000;
        repeat (12) tick();
        check("par_hits", watch_hits, 1);
        check("par_total", nz_hits, 1);
        $display("parallel: hits=%0d", watch_hits);

        // Reversal with no gap restarts the hold timing.
        watch(12'h004);
        mark = edge_n;
        btn_raw = 12'h008;
        repeat (30) tick();
        btn_raw = 12'h004;
        repeat (40) tick();
        btn_raw = 12'h000;
        repeat (12) tick();
        check("rev_first", watch_first - mark, 37);
        check("rev_hits", watch_hits, 4);
        $display("reversal: first=%0d hits=%0d", watch_first - mark, watch_hits);

        // Reset in the middle of auto-repeat, button still held.
        mark = edge_n;
        btn_raw = 12'h080;
        repeat (35) tick();
        check("pre_rst_pad", {20'd0, controlPad}, 32'h080);
        #2;
        rst = 1'b1;
        #1;
        check("rst_pad", {20'd0, controlPad}, 32'h0);
        check("rst_act", {31'd0, pad_active}, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        watch(12'h080);
        repeat (10) tick();
        check("post_rst_hits", watch_hits, 1);
        check("post_rst_lat", watch_first, 7);
        btn_raw = 12'h000;
        repeat (12) tick();
        $display("reset: hits=%0d latency=%0d", watch_hits, watch_first);

        // Long hold; the repeat spacing depends on the acceleration option.
        watch(12'h400);
        btn_raw = 12'h400;
        repeat (110) tick();
        btn_raw = 12'h000;
        repeat (12) tick();
`ifdef PAD_ACCEL_EN
        check("long_hits", watch_hits, 22);
`else
        check("long_hits", watch_hits, 13);
`endif
        $display("long hold: hits=%0d", watch_hits);

        // Random patterns, checked each cycle against the model.
        for (int i = 0; i < 40; i++) begin
            btn_raw = 12'($urandom) & 12'($urandom);
            n = $urandom_range(1, 30);
            repeat (n) tick();
            $display("random %0d: btn=%h cycles=%0d", i, btn_raw, n);
        end
        btn_raw = 12'h000;
        repeat (30) tick();
        check("final_act", {31'd0, pad_active}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
